// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
//
// Direct-mapped branch target buffer with a 2-bit saturating direction
// counter per entry. Lookup is combinational and update is registered.
// Optional gshare indexing is built when the macro BTB_GSHARE_EN is defined.
// In that build the PC index bits are XORed with a global history register
// that records resolved branch directions.
//
// Parameters
//   ENTRIES     number of table entries (power of two, 4..256)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-low reset
//   lookup_en   fetch presents a new PC this cycle
//   fetch_pc    fetch address to look up
//   pred        predict taken (combinational)
//   pred_addr   predicted target, zero when pred is low
//   upd_valid   resolved control-flow update presented this cycle
//   upd_pc      PC of the resolved instruction
//   upd_br      resolved instruction is a branch/jump
//   upd_taken   resolved direction
//   upd_target  resolved target address
//   hit_cnt     saturating count of cycles with pred high
// -----------------------------------------------------------------------------
module branch_target_buffer #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup_en,
    input  logic [31:0] fetch_pc,
    output logic        pred,
    output logic [31:0] pred_addr,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_br,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [15:0] hit_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    // ------------------------------------------------------------------
    // Table storage. valid and ctr are reset; tag and target are only
    // meaningful behind a set valid bit, so they carry no reset.
    // Target bit 0 is always zero and is not stored.
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [1:0]         ctr_q  [ENTRIES];
    logic [1:0]         ctr_d  [ENTRIES];
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [30:0]        tgt_q  [ENTRIES];
    logic [15:0]        hit_cnt_q, hit_cnt_d;

    logic [IDX_W-1:0]   lk_idx;
    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [TAG_W-1:0]   up_tag;
    logic               lk_hit;
    logic               up_hit;
    logic               tag_we;
    logic               tgt_we;

    assign lk_tag = fetch_pc[31:IDX_W+2];
    assign up_tag = upd_pc[31:IDX_W+2];

    // ------------------------------------------------------------------
    // Index generation
    // ------------------------------------------------------------------
`ifdef BTB_GSHARE_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;

    // The update that shifts the history still indexes with the
    // pre-shift value, so both indices use ghr_q.
    assign lk_idx = fetch_pc[IDX_W+1:2] ^ ghr_q;
    assign up_idx = upd_pc[IDX_W+1:2] ^ ghr_q;

    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid && upd_br) begin
            ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign lk_idx = fetch_pc[IDX_W+1:2];
    assign up_idx = upd_pc[IDX_W+1:2];
`endif

    // ------------------------------------------------------------------
    // Lookup: purely combinational on current table contents, so a
    // same-cycle update at the same index is not visible until next cycle.
    // ------------------------------------------------------------------
    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred      = lookup_en && lk_hit && ctr_q[lk_idx][1];
    assign pred_addr = pred ? {tgt_q[lk_idx], 1'b0} : '0;

    // ------------------------------------------------------------------
    // Update decode
    // ------------------------------------------------------------------
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        valid_d = valid_q;
        ctr_d   = ctr_q;
        tag_we  = 1'b0;
        tgt_we  = 1'b0;
        if (upd_valid) begin
            if (up_hit) begin
                if (!upd_br) begin
                    // A non-branch aliasing onto this entry: drop it.
                    valid_d[up_idx] = 1'b0;
                end else if (upd_taken) begin
                    if (ctr_q[up_idx] != 2'b11) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    end
                    tgt_we = 1'b1;
                end else begin
                    if (ctr_q[up_idx] != 2'b00) begin
                        ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                    end
                end
            end else if (upd_br && upd_taken) begin
                // Allocate on a taken miss, evicting whatever is there.
                valid_d[up_idx] = 1'b1;
                ctr_d[up_idx]   = 2'b10;
                tag_we          = 1'b1;
                tgt_we          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[up_idx] <= up_tag;
        end
        if (tgt_we) begin
            tgt_q[up_idx] <= upd_target[31:1];
        end
    end

    // ------------------------------------------------------------------
    // Prediction counter, saturating at all-ones
    // ------------------------------------------------------------------
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (pred && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;

    // Word-aligned PCs: the byte-offset bits carry no information here.
    logic unused_bits;
    assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_target[0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

    localparam int unsigned E  = 16;
    localparam int unsigned IW = $clog2(E);

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_en;
    logic [31:0] fetch_pc;
    logic        pred;
    logic [31:0] pred_addr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_br;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [15:0] hit_cnt;

    branch_target_buffer #(.ENTRIES(E)) dut (
        .clk        (clk),
        .rst        (rst),
        .lookup_en  (lookup_en),
        .fetch_pc   (fetch_pc),
        .pred       (pred),
        .pred_addr  (pred_addr),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_br     (upd_br),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .hit_cnt    (hit_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // ------------------------------------------------------------------
    // Reference model: table of records indexed by (pc/4 ^ history) mod E
    // ------------------------------------------------------------------
    bit          m_v   [E];
    int unsigned m_tag [E];
    logic [31:0] m_tgt [E];
    int          m_ctr [E];
    int unsigned m_hc;
    int unsigned m_ghr;

    function automatic int unsigned m_idx(input logic [31:0] pc);
        return ((int'(pc) >>> 0) >> 2 ^ m_ghr) % E;
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        return pc >> (IW + 2);
    endfunction

    function automatic bit m_pred(input logic le, input logic [31:0] pc);
        int unsigned i;
        i = m_idx(pc);
        return le && m_v[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < E; i++) begin
            m_v[i]   = 0;
            m_ctr[i] = 0;
        end
        m_hc  = 0;
        m_ghr = 0;
    endfunction

    function automatic void m_update(input logic uv, input logic [31:0] pc,
                                     input logic br, input logic tk,
                                     input logic [31:0] tgt);
        int unsigned i;
        bit hit;
        if (!uv) return;
        i   = m_idx(pc);
        hit = m_v[i] && (m_tag[i] == m_tagof(pc));
        if (hit) begin
            if (!br)     m_v[i] = 0;
            else if (tk) begin
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = tgt & 32'hFFFF_FFFE;
            end else begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (br && tk) begin
            m_v[i]   = 1;
            m_tag[i] = m_tagof(pc);
            m_tgt[i] = tgt & 32'hFFFF_FFFE;
            m_ctr[i] = 2;
        end
`ifdef BTB_GSHARE_EN
        if (br) m_ghr = ((m_ghr << 1) | tk) % E;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check lookup outputs before the edge,
    // advance model at posedge, check hit_cnt after the edge.
    task automatic step(input logic le, input logic [31:0] fpc,
                        input logic uv, input logic [31:0] upc,
                        input logic ubr, input logic utk, input logic [31:0] utgt,
                        input bit use_tab, input logic tp,
                        input logic [31:0] tpa, input logic [15:0] thc,
                        input string nm);
        bit          mp;
        logic [31:0] mpa;
        @(negedge clk);
        lookup_en  = le;
        fetch_pc   = fpc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_br     = ubr;
        upd_taken  = utk;
        upd_target = utgt;
        #1;
        mp  = m_pred(le, fpc);
        mpa = mp ? m_tgt[m_idx(fpc)] : 32'h0;
        chk({nm, ".pred"},      {31'h0, pred}, use_tab ? {31'h0, tp} : {31'h0, mp});
        chk({nm, ".pred_addr"}, pred_addr,     use_tab ? tpa : mpa);
        @(posedge clk);
        if (mp && m_hc < 65535) m_hc++;
        m_update(uv, upc, ubr, utk, utgt);
        #1;
        chk({nm, ".hit_cnt"}, {16'h0, hit_cnt}, use_tab ? {16'h0, thc} : m_hc);
    endtask

    typedef struct {
        logic        le;
        logic [31:0] fpc;
        logic        uv;
        logic [31:0] upc;
        logic        ubr;
        logic        utk;
        logic [31:0] utgt;
        logic        ep;
        logic [31:0] epa;
        logic [15:0] ehc;
    } vec_t;

    vec_t tab[$];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        bit tab_exact;
        logic [31:0] pc_a;
        int unsigned sat_cycles;

`ifdef BTB_GSHARE_EN
        tab_exact = 0;
`else
        tab_exact = 1;
`endif
        //           le fpc           uv upc           br tk tgt            pred addr           hc
        tab.push_back('{1, 32'h100,     0, 32'h0,      0, 0, 32'h0,         0, 32'h0,           16'd0});
        tab.push_back('{0, 32'hDEAD_BEEF,1, 32'h100,    1, 1, 32'h241,       0, 32'h0,           16'd0});
        tab.push_back('{1, 32'h100,     0, 32'h100,    0, 0, 32'h0,         1, 32'h240,         16'd1});
        tab.push_back('{1, 32'h100,     1, 32'h100,    1, 0, 32'h0,         1, 32'h240,         16'd2});
        tab.push_back('{1, 32'h100,     1, 32'h100,    1, 0, 32'h0,         0, 32'h0,           16'd2});
        tab.push_back('{0, 32'h100,     1, 32'h100,    1, 0, 32'h0,         0, 32'h0,           16'd2});
        tab.push_back('{1, 32'h100,     1, 32'h100,    1, 1, 32'h241,       0, 32'h0,           16'd2});
        tab.push_back('{1, 32'h100,     1, 32'h100,    1, 1, 32'h241,       0, 32'h0,           16'd2});
        tab.push_back('{1, 32'h100,     0, 32'h0,      0, 0, 32'h0,         1, 32'h240,         16'd3});
        tab.push_back('{1, 32'h100,     1, 32'h140,    1, 1, 32'h80,        1, 32'h240,         16'd4});
        tab.push_back('{1, 32'h100,     0, 32'h0,      0, 0, 32'h0,         0, 32'h0,           16'd4});
        tab.push_back('{1, 32'h140,     0, 32'h0,      0, 0, 32'h0,         1, 32'h80,          16'd5});
        tab.push_back('{1, 32'h300,     1, 32'h300,    1, 1, 32'h500,       0, 32'h0,           16'd5});
        tab.push_back('{1, 32'h300,     0, 32'h0,      0, 0, 32'h0,         1, 32'h500,         16'd6});
        tab.push_back('{1, 32'h300,     1, 32'h300,    0, 0, 32'h0,         1, 32'h500,         16'd7});
        tab.push_back('{1, 32'h300,     0, 32'h0,      0, 0, 32'h0,         0, 32'h0,           16'd7});
        tab.push_back('{0, 32'h0,       1, 32'h104,    1, 1, 32'h1001,      0, 32'h0,           16'd7});
        tab.push_back('{1, 32'h104,     1, 32'h104,    1, 1, 32'h2223,      1, 32'h1000,        16'd8});
        tab.push_back('{1, 32'h104,     0, 32'h0,      0, 0, 32'h0,         1, 32'h2222,        16'd9});
        tab.push_back('{1, 32'h104,     1, 32'h144,    1, 0, 32'h0,         1, 32'h2222,        16'd10});
        tab.push_back('{1, 32'h104,     0, 32'h0,      0, 0, 32'h0,         1, 32'h2222,        16'd11});

        rst        = 1'b0;
        lookup_en  = 1'b0;
        fetch_pc   = '0;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_br     = 1'b0;
        upd_taken  = 1'b0;
        upd_target = '0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("reset.hit_cnt", {16'h0, hit_cnt}, 32'h0);
        rst = 1'b1;

        // Directed table
        foreach (tab[k]) begin
            step(tab[k].le, tab[k].fpc, tab[k].uv, tab[k].upc, tab[k].ubr,
                 tab[k].utk, tab[k].utgt, tab_exact, tab[k].ep, tab[k].epa,
                 tab[k].ehc, $sformatf("tab%0d", k));
        end

        // Randomized traffic over a small PC space to force hits and aliases
        for (int n = 0; n < 600; n++) begin
            logic        le, uv, ubr, utk;
            logic [31:0] fpc, upc, utgt;
            le   = ($urandom_range(0, 3) != 0);
            uv   = ($urandom_range(0, 1) != 0);
            ubr  = ($urandom_range(0, 5) != 0);
            utk  = ($urandom_range(0, 2) != 0);
            fpc  = le ? ((32'($urandom_range(0, 2)) << (IW + 2)) | (32'($urandom_range(0, 3)) << 2))
                      : $urandom();
            upc  = uv ? ((32'($urandom_range(0, 2)) << (IW + 2)) | (32'($urandom_range(0, 3)) << 2))
                      : $urandom();
            utgt = $urandom();
            step(le, fpc, uv, upc, ubr, utk, utgt, 0, 0, 0, 0, $sformatf("rnd%0d", n));
        end

        // hit_cnt saturation
        pc_a = 32'h8000_0010;
        step(0, 32'h0, 1, pc_a, 1, 1, 32'h1234_5679, 0, 0, 0, 0, "sat.alloc");
        step(1, pc_a,  0, 32'h0, 0, 0, 32'h0,        0, 0, 0, 0, "sat.look");
        @(negedge clk);
        lookup_en = 1'b1;
        fetch_pc  = pc_a;
        upd_valid = 1'b0;
        sat_cycles = 65540;
        repeat (sat_cycles) @(posedge clk);
        m_hc = (m_hc + sat_cycles > 65535) ? 65535 : m_hc + sat_cycles;
        #1;
        chk("sat.hit_cnt", {16'h0, hit_cnt}, m_hc);
        step(1, pc_a, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, "sat.hold");

        // Asynchronous reset in the middle of an update to a valid entry
        @(negedge clk);
        lookup_en  = 1'b1;
        fetch_pc   = pc_a;
        upd_valid  = 1'b1;
        upd_pc     = pc_a;
        upd_br     = 1'b1;
        upd_taken  = 1'b1;
        upd_target = 32'h0000_9999;
        #1;
        chk("arst.pre_pred", {31'h0, pred}, {31'h0, m_pred(1, pc_a)});
        #1;
        rst = 1'b0;
        #1;
        m_reset();
        chk("arst.pred",      {31'h0, pred}, 32'h0);
        chk("arst.pred_addr", pred_addr,     32'h0);
        chk("arst.hit_cnt",   {16'h0, hit_cnt}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        rst       = 1'b1;
        #1;
        chk("arst.post_pred", {31'h0, pred}, 32'h0);
        step(1, pc_a, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, "arst.look");
        step(1, pc_a, 1, pc_a,  1, 1, 32'h0000_4444, 0, 0, 0, 0, "arst.realloc");
        step(1, pc_a, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, "arst.hit");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
